mem_port_arbiter: RTL

- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits inside core_top, between the fetch/LSU stages and the external memory interface.
- Allows one outstanding transaction at a time.
- Registers all memory-side outputs, sequences request, then response, and bounds every wait with a response timeout.

---
 rtl/core_pkg.sv | 19 +
 rtl/mem_arb_timeout.sv | 33 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and default widths for the core's memory-side blocks.
package core_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Response-wait counter: clear/load/increment, saturating at MAX_COUNT.
// expired flags the counting cycle whose increment reaches MAX_COUNT.
module mem_arb_timeout #(
    parameter int MAX_COUNT = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           enable,
    input  logic                           load,
    input  logic [$clog2(MAX_COUNT+1)-1:0] load_value,
    output logic                           expired
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != CW'(MAX_COUNT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(MAX_COUNT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (D), one transaction at a time.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of D-first.
//
//   state | meaning
//   IDLE  | no transaction; granted requester sees ready
//   REQ   | mem_req_valid held with latched fields until mem_req_ready
//   RSP   | waiting for mem_rsp_valid, bounded by the timeout counter
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic              grant_d, grant_if, accept;
    logic              tmo_clear, tmo_en, tmo_expired, finish;
    logic [DATA_W-1:0] rsp_fill;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    always_comb begin
        grant_d  = d_req_valid;
        grant_if = if_req_valid && !d_req_valid;
        if (d_req_valid && if_req_valid) begin
            grant_d  = (last_grant == OWN_IF);
            grant_if = (last_grant == OWN_D);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_IF;
        end else if (accept) begin
            last_grant <= grant_d ? OWN_D : OWN_IF;
        end
    end
`else
    always_comb begin
        grant_d  = d_req_valid;
        grant_if = if_req_valid && !d_req_valid;
    end
`endif

    // Readies are forced low while reset is held so every output reads 0 in reset.
    assign accept       = (state == IDLE) && (grant_d || grant_if);
    assign d_req_ready  = reset && (state == IDLE) && grant_d;
    assign if_req_ready = reset && (state == IDLE) && grant_if;

    assign tmo_clear = (state == REQ) && mem_req_ready;
    assign tmo_en    = (state == RSP);
    assign finish    = (state == RSP) && (mem_rsp_valid || tmo_expired);
    assign rsp_fill  = (mem_rsp_valid && !mem_req_we) ? mem_rsp_data : '0;

    mem_arb_timeout #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear      (tmo_clear),
        .enable     (tmo_en),
        .load       (1'b0),
        .load_value ({CW{1'b0}}),
        .expired    (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RSP;
            RSP:     if (finish)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner         <= OWN_IF;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            d_rsp_valid   <= 1'b0;
            d_rsp_data    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            timeout_err  <= 1'b0;
            if (accept) begin
                mem_req_valid <= 1'b1;
                owner         <= grant_d ? OWN_D : OWN_IF;
                mem_req_addr  <= grant_d ? d_req_addr : if_req_addr;
                mem_req_we    <= grant_d && d_req_we;
                mem_req_wdata <= grant_d ? d_req_wdata : '0;
                mem_req_be    <= grant_d ? d_req_be : '1;
            end
            if (tmo_clear) begin
                mem_req_valid <= 1'b0;
            end
            // A response in the expiring cycle takes precedence over the abort.
            if (finish) begin
                timeout_err <= !mem_rsp_valid;
                if (owner == OWN_D) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= rsp_fill;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= rsp_fill;
                end
            end
        end
    end

endmodule
